// File: rtl/uart_boot_loader.sv
// Boot sequencer: takes a length byte plus image over UART, writes imem 0..N-1, then releases CPU reset. Echo option: LOADER_ECHO_EN.
// Latency: imem write 1 cycle after rx_valid; cpu_rst_n rises the cycle after the final write.
// Backpressure: none on rx (every strobe is consumed); echo waits on tx_busy behind a 1-entry buffer and drops on overflow.
module uart_boot_loader #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              echo_ovf
);

    localparam int RW = ADDR_W + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_LEN = 2'd0,
        LOAD     = 2'd1,
        DONE     = 2'd2,
        ERROR    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [RW-1:0]     remaining;
    logic [ADDR_W-1:0] waddr;
    logic [TW-1:0]     timer;
    logic [8:0]        len_val;
    logic              len_ok;
    logic              timeout;

    always_comb begin
        len_val = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        len_ok  = ({23'd0, len_val} <= (32'd1 << ADDR_W));
        timeout = (timer == TW'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        state_nxt = state;
        if (reload) begin
            state_nxt = WAIT_LEN;
        end else begin
            case (state)
                WAIT_LEN: if (rx_valid) state_nxt = len_ok ? LOAD : ERROR;
                // remaining hits 0 only after the last write has been issued
                LOAD: begin
                    if (remaining == '0)
                        state_nxt = DONE;
                    else if (!rx_valid && timeout)
                        state_nxt = ERROR;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_LEN;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 8'd0;
            cpu_rst_n  <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            remaining  <= '0;
            waddr      <= '0;
            timer      <= '0;
        end else begin
            imem_we   <= 1'b0;
            busy      <= (state_nxt == LOAD);
            load_done <= (state_nxt == DONE);
            load_err  <= (state_nxt == ERROR);
            cpu_rst_n <= (state_nxt == DONE);
            if (reload) begin
                remaining <= '0;
                waddr     <= '0;
                imem_addr <= '0;
                timer     <= '0;
            end else begin
                case (state)
                    WAIT_LEN: begin
                        if (rx_valid) begin
                            remaining <= RW'(len_val);
                            waddr     <= '0;
                            imem_addr <= '0;
                            timer     <= '0;
                        end
                    end
                    LOAD: begin
                        if (rx_valid && remaining != '0) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= waddr;
                            imem_wdata <= rx_data;
                            waddr      <= waddr + ADDR_W'(1);
                            remaining  <= remaining - RW'(1);
                        end
                        if (rx_valid) timer <= '0;
                        else          timer <= timer + TW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_ECHO_EN
    logic       accept;
    logic       tx_idle;
    logic       buf_full;
    logic [7:0] echo_buf;

    // tx_start guard: the transmitter raises tx_busy a cycle after the strobe
    always_comb begin
        accept  = rx_valid && !reload &&
                  (state == WAIT_LEN || (state == LOAD && remaining != '0));
        tx_idle = !tx_busy && !tx_start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start <= 1'b0;
            tx_data  <= 8'd0;
            echo_ovf <= 1'b0;
            buf_full <= 1'b0;
            echo_buf <= 8'd0;
        end else begin
            tx_start <= 1'b0;
            if (reload) begin
                buf_full <= 1'b0;
                echo_ovf <= 1'b0;
            end else begin
                if (buf_full && tx_idle) begin
                    tx_start <= 1'b1;
                    tx_data  <= echo_buf;
                    buf_full <= 1'b0;
                end
                if (accept) begin
                    if (!buf_full && tx_idle) begin
                        tx_start <= 1'b1;
                        tx_data  <= rx_data;
                    end else if (!buf_full || tx_idle) begin
                        echo_buf <= rx_data;
                        buf_full <= 1'b1;
                    end else begin
                        echo_ovf <= 1'b1;
                    end
                end
            end
        end
    end
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_start = 1'b0;
    assign tx_data  = 8'd0;
    assign echo_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: random gaps/data/lengths against an image-level model of the expected imem writes.
// Runs with TIMEOUT_CYCLES=1000; echo checks follow LOADER_ECHO_EN.
module tb_uart_boot_loader;
    localparam int ADDR_W = 8;
    localparam int TMO    = 1000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              reload = 1'b0;
    logic              tx_busy = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              load_done;
    logic              load_err;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              echo_ovf;

    always #5 clk = ~clk;

    uart_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .reload(reload),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n),
        .busy(busy), .load_done(load_done), .load_err(load_err), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .echo_ovf(echo_ovf)
    );

    typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
    wr_t        wq[$];
    wr_t        eq[$];
    logic [7:0] dut_img[256];
    logic [7:0] exp_img[256];
    int         vectors = 0;
    int         miscompares = 0;
    int         ncyc = 0;
    int         last_we = -100;
    int         rise = -100;
    int         tx_cnt = 0;
    logic [7:0] tx_last = 8'd0;
    logic       cpu_prev = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (imem_we) begin
            wq.push_back({imem_addr, imem_wdata});
            dut_img[imem_addr] = imem_wdata;
            last_we = ncyc;
        end
        if (cpu_rst_n && !cpu_prev) rise = ncyc;
        cpu_prev = cpu_rst_n;
        if (tx_start) begin
            tx_cnt++;
            tx_last = tx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(gap);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick(1);
        reload = 1'b0;
    endtask

    task automatic expect_wr(input int k, input logic [7:0] b);
        eq.push_back({8'(k), b});
        exp_img[k] = b;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_wr_count"}, wq.size(), eq.size());
        n = (wq.size() < eq.size()) ? wq.size() : eq.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_wr_addr"}, wq[i].a, eq[i].a);
            check({tag, "_wr_data"}, wq[i].d, eq[i].d);
        end
        wq.delete();
        eq.delete();
    endtask

    task automatic check_status(input string tag, input logic b, input logic d, input logic e, input logic c);
        check({tag, "_busy"}, busy, b);
        check({tag, "_done"}, load_done, d);
        check({tag, "_err"}, load_err, e);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, "_we"}, imem_we, 1'b0);
        check({tag, "_addr"}, imem_addr, 8'd0);
        check({tag, "_wdata"}, imem_wdata, 8'd0);
        check({tag, "_tx_start"}, tx_start, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'd0);
        check({tag, "_echo_ovf"}, echo_ovf, 1'b0);
    endtask

    initial begin
        logic [7:0] img1[3];
        logic [7:0] b;
        int         len;
        int         nsend;
        bit         abort;

        for (int i = 0; i < 256; i++) begin
            dut_img[i] = 8'd0;
            exp_img[i] = 8'd0;
        end
        img1[0] = 8'hA5; img1[1] = 8'h5A; img1[2] = 8'hFF;

        #23;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);

        // 3-byte image; cpu released one cycle after the final write
        rise = -100;
        send_byte(8'd3, $urandom_range(0, 2));
        check("t1_busy_in_load", busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            send_byte(img1[k], $urandom_range(0, 3));
            expect_wr(k, img1[k]);
        end
        tick(3);
        compare_writes("t1");
        check_status("t1", 1'b0, 1'b1, 1'b0, 1'b1);
        check("t1_cpu_release_lag", rise - last_we, 1);

        // bytes after DONE are ignored
        send_byte(8'h77, 1);
        send_byte(8'h88, 2);
        compare_writes("t4");
        check_status("t4", 1'b0, 1'b1, 1'b0, 1'b1);

        pulse_reload();
        check_status("reload_done", 1'b0, 1'b0, 1'b0, 1'b0);

        // length 0 means a full 256-byte image
        send_byte(8'd0, 1);
        for (int k = 0; k < 256; k++) begin
            send_byte(8'(k), $urandom_range(0, 2));
            expect_wr(k, 8'(k));
        end
        tick(3);
        compare_writes("t2");
        check_status("t2", 1'b0, 1'b1, 1'b0, 1'b1);

        // stalled stream times out
        pulse_reload();
        send_byte(8'd2, 0);
        send_byte(8'h11, 0);
        expect_wr(0, 8'h11);
        tick(TMO - 100);
        check_status("t3_pre_timeout", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(120);
        check_status("t3_timeout", 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(8'h99, 2);
        compare_writes("t3");
        pulse_reload();
        check_status("t3_reload", 1'b0, 1'b0, 1'b0, 1'b0);

        // reload wins over a same-cycle length byte
        rx_data  = 8'd5;
        rx_valid = 1'b1;
        reload   = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        reload   = 1'b0;
        tick(1);
        check("reload_prio_busy", busy, 1'b0);
        b = 8'($urandom);
        send_byte(8'd1, 0);
        send_byte(b, 3);
        expect_wr(0, b);
        compare_writes("reload_prio");
        check_status("reload_prio", 1'b0, 1'b1, 1'b0, 1'b1);

        // async reset mid-load, then a fresh load
        pulse_reload();
        send_byte(8'd4, 0);
        send_byte(8'hC1, 0);
        expect_wr(0, 8'hC1);
        send_byte(8'hC2, 1);
        expect_wr(1, 8'hC2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_async_reset");
        tick(2);
        rst_n = 1'b1;
        tick(1);
        send_byte(8'd1, 1);
        send_byte(8'h3C, 3);
        expect_wr(0, 8'h3C);
        compare_writes("t5");
        check_status("t5", 1'b0, 1'b1, 1'b0, 1'b1);

        // random images, some aborted partway by reload
        for (int it = 0; it < 8; it++) begin
            pulse_reload();
            len   = $urandom_range(1, 40);
            abort = ($urandom_range(0, 3) == 0);
            nsend = abort ? $urandom_range(0, len - 1) : len;
            rise  = -100;
            send_byte(8'(len), $urandom_range(0, 3));
            for (int k = 0; k < nsend; k++) begin
                b = 8'($urandom);
                send_byte(b, $urandom_range(0, 3));
                expect_wr(k, b);
            end
            if (abort) pulse_reload();
            tick(4);
            compare_writes("rand");
            check_status("rand", 1'b0, !abort, 1'b0, !abort);
            if (!abort) check("rand_cpu_release_lag", rise - last_we, 1);
        end

`ifdef LOADER_ECHO_EN
        tx_busy = 1'b1;
        pulse_reload();
        tick(2);
        tx_cnt = 0;
        send_byte(8'h02, 0);
        send_byte(8'h10, 0);
        send_byte(8'h20, 2);
        expect_wr(0, 8'h10);
        expect_wr(1, 8'h20);
        check("t6_echo_ovf", echo_ovf, 1'b1);
        check("t6_no_tx_while_busy", tx_cnt, 0);
        tx_busy = 1'b0;
        tick(6);
        check("t6_tx_count", tx_cnt, 1);
        check("t6_tx_data", tx_last, 8'h02);
        compare_writes("t6");
        check_status("t6", 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_reload();
        check("t6_ovf_cleared", echo_ovf, 1'b0);
`else
        check("no_echo_tx_count", tx_cnt, 0);
        check("no_echo_tx_data", tx_data, 8'd0);
        check("no_echo_ovf", echo_ovf, 1'b0);
`endif

        for (int i = 0; i < 256; i++) check("image", dut_img[i], exp_img[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
